// File: rtl/adc_cfg_sequencer.sv
// ADC configuration sequencer: waits out ADC power-up, writes and optionally verifies a
// fixed register table with bounded retry, then serves host register accesses over SPI.
module adc_cfg_sequencer #(
  parameter int unsigned PWRUP_CYCLES = 1000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned ACK_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reinit,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [12:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_ack,
  output logic        init_done,
  output logic        init_err,
  output logic [12:0] err_addr,
  output logic        cmd_read,
  output logic        cmd_write,
  output logic [12:0] read_addr,
  output logic [12:0] write_addr,
  output logic [7:0]  write_data,
  input  logic [7:0]  read_data,
  input  logic        cmd_read_ack,
  input  logic        cmd_write_ack,
  output logic [2:0]  dbg_state
);

  localparam int PW_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RT_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  typedef enum logic [2:0] {
    S_PWRUP    = 3'd0,
    S_CFG_WR   = 3'd1,
    S_CFG_RD   = 3'd2,
    S_CFG_NEXT = 3'd3,
    S_READY    = 3'd4,
    S_HOST     = 3'd5,
    S_FAIL     = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [PW_W-1:0] pw_cnt_q, pw_cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [RT_W-1:0] retry_q, retry_d;
  logic [1:0]      idx_q, idx_d;
  logic            cmd_write_q, cmd_write_d, cmd_read_q, cmd_read_d;
  logic [12:0]     write_addr_q, write_addr_d, read_addr_q, read_addr_d;
  logic [7:0]      write_data_q, write_data_d;
  logic            host_ack_q, host_ack_d;
  logic [7:0]      host_rdata_q, host_rdata_d;
  logic            init_done_q, init_done_d, init_err_q, init_err_d;
  logic [12:0]     err_addr_q, err_addr_d;
  logic            lat_wr_q, lat_wr_d, from_fail_q, from_fail_d;
  logic [12:0]     lat_addr_q, lat_addr_d;
  logic [7:0]      lat_wdata_q, lat_wdata_d;

  logic [12:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_verify;
  logic        wr_ack, rd_ack, cmd_busy, timeout;

  always_comb begin
    rom_addr   = 13'h000;
    rom_data   = 8'h3C;
    rom_verify = 1'b0;
    case (idx_q)
      2'd1: begin rom_addr = 13'h014; rom_data = 8'h01; rom_verify = 1'b1; end
      2'd2: begin rom_addr = 13'h00D; rom_data = 8'h00; rom_verify = 1'b1; end
      2'd3: begin rom_addr = 13'h0FF; rom_data = 8'h01; rom_verify = 1'b0; end
      default: ;
    endcase
  end

  // SPI handshake: a command is outstanding while cmd_* is high; an ack of the matching
  // type is accepted only then, and the command drops on the clock that samples the ack.
  assign wr_ack   = cmd_write_q && cmd_write_ack;
  assign rd_ack   = cmd_read_q && cmd_read_ack;
  assign cmd_busy = cmd_write_q || cmd_read_q;
  assign timeout  = cmd_busy && !wr_ack && !rd_ack && (wd_q == WD_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    pw_cnt_d     = pw_cnt_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    cmd_write_d  = 1'b0;
    cmd_read_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    read_addr_d  = read_addr_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    init_done_d  = init_done_q;
    init_err_d   = init_err_q;
    err_addr_d   = err_addr_q;
    lat_wr_d     = lat_wr_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    from_fail_d  = from_fail_q;

    unique case (state_q)
      S_PWRUP: begin
        pw_cnt_d = pw_cnt_q + PW_W'(1);
        if (pw_cnt_q == PW_W'(PWRUP_CYCLES - 1)) begin
          state_d = S_CFG_WR;
          idx_d   = 2'd0;
          retry_d = '0;
        end
      end
      S_CFG_WR: begin
        write_addr_d = rom_addr;
        write_data_d = rom_data;
        if (timeout) begin
          err_addr_d = rom_addr;
          init_err_d = 1'b1;
          state_d    = S_FAIL;
        end else if (wr_ack) begin
          state_d = rom_verify ? S_CFG_RD : S_CFG_NEXT;
        end else begin
          cmd_write_d = 1'b1;
        end
      end
      S_CFG_RD: begin
        read_addr_d = rom_addr;
        if (timeout) begin
          err_addr_d = rom_addr;
          init_err_d = 1'b1;
          state_d    = S_FAIL;
        end else if (rd_ack) begin
          if (read_data == rom_data) begin
            state_d = S_CFG_NEXT;
          end else if (retry_q == RT_W'(MAX_RETRY - 1)) begin
            err_addr_d = rom_addr;
            init_err_d = 1'b1;
            state_d    = S_FAIL;
          end else begin
            retry_d = retry_q + RT_W'(1);
            state_d = S_CFG_WR;
          end
        end else begin
          cmd_read_d = 1'b1;
        end
      end
      S_CFG_NEXT: begin
        retry_d = '0;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          init_done_d = 1'b1;
          state_d     = S_READY;
        end else begin
          state_d = S_CFG_WR;
        end
      end
      S_READY, S_FAIL: begin
        if (reinit) begin
          init_done_d = 1'b0;
          init_err_d  = 1'b0;
          idx_d       = 2'd0;
          retry_d     = '0;
          state_d     = S_CFG_WR;
        end else if (host_req) begin
          lat_wr_d    = host_wr;
          lat_addr_d  = host_addr;
          lat_wdata_d = host_wdata;
          from_fail_d = (state_q == S_FAIL);
          state_d     = S_HOST;
        end
      end
      S_HOST: begin
        if (lat_wr_q) begin
          write_addr_d = lat_addr_q;
          write_data_d = lat_wdata_q;
        end else begin
          read_addr_d = lat_addr_q;
        end
        if (timeout) begin
          host_ack_d   = 1'b1;
          host_rdata_d = 8'h00;
          err_addr_d   = lat_addr_q;
          init_err_d   = 1'b1;
          state_d      = S_FAIL;
        end else if ((lat_wr_q && wr_ack) || (!lat_wr_q && rd_ack)) begin
          host_ack_d = 1'b1;
          if (!lat_wr_q) host_rdata_d = read_data;
          state_d = from_fail_q ? S_FAIL : S_READY;
        end else begin
          cmd_write_d = lat_wr_q;
          cmd_read_d  = !lat_wr_q;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    // Watchdog restarts from zero with every newly raised command.
    wd_d = ((cmd_write_d || cmd_read_d) && cmd_busy) ? wd_q + WD_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_PWRUP;
      pw_cnt_q     <= '0;
      wd_q         <= '0;
      retry_q      <= '0;
      idx_q        <= 2'd0;
      cmd_write_q  <= 1'b0;
      cmd_read_q   <= 1'b0;
      write_addr_q <= 13'h000;
      write_data_q <= 8'h00;
      read_addr_q  <= 13'h000;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'h00;
      init_done_q  <= 1'b0;
      init_err_q   <= 1'b0;
      err_addr_q   <= 13'h000;
      lat_wr_q     <= 1'b0;
      lat_addr_q   <= 13'h000;
      lat_wdata_q  <= 8'h00;
      from_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pw_cnt_q     <= pw_cnt_d;
      wd_q         <= wd_d;
      retry_q      <= retry_d;
      idx_q        <= idx_d;
      cmd_write_q  <= cmd_write_d;
      cmd_read_q   <= cmd_read_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      read_addr_q  <= read_addr_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      init_done_q  <= init_done_d;
      init_err_q   <= init_err_d;
      err_addr_q   <= err_addr_d;
      lat_wr_q     <= lat_wr_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      from_fail_q  <= from_fail_d;
    end
  end

  assign host_rdata = host_rdata_q;
  assign host_ack   = host_ack_q;
  assign init_done  = init_done_q;
  assign init_err   = init_err_q;
  assign err_addr   = err_addr_q;
  assign cmd_read   = cmd_read_q;
  assign cmd_write  = cmd_write_q;
  assign read_addr  = read_addr_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Bench for adc_cfg_sequencer: randomized-latency SPI device model, expected command queue
// derived from the init table rules, directed phases for retry, watchdog, reinit and reset.
module tb_adc_cfg_sequencer;

  localparam int P  = 16;
  localparam int MR = 3;
  localparam int TO = 32;

  localparam logic [12:0] T_ADDR [4] = '{13'h000, 13'h014, 13'h00D, 13'h0FF};
  localparam logic [7:0]  T_DATA [4] = '{8'h3C, 8'h01, 8'h00, 8'h01};
  localparam bit          T_VER  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reinit = 1'b0;
  logic        host_req = 1'b0;
  logic        host_wr = 1'b0;
  logic [12:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic [7:0]  host_rdata;
  logic        host_ack, init_done, init_err;
  logic [12:0] err_addr;
  logic        cmd_read, cmd_write;
  logic [12:0] read_addr, write_addr;
  logic [7:0]  write_data;
  logic [7:0]  read_data = '0;
  logic        cmd_read_ack = 1'b0;
  logic        cmd_write_ack = 1'b0;
  logic [2:0]  dbg_state;

  adc_cfg_sequencer #(.PWRUP_CYCLES(P), .MAX_RETRY(MR), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .reinit(reinit),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .init_done(init_done), .init_err(init_err), .err_addr(err_addr),
    .cmd_read(cmd_read), .cmd_write(cmd_write), .read_addr(read_addr),
    .write_addr(write_addr), .write_data(write_data), .read_data(read_data),
    .cmd_read_ack(cmd_read_ack), .cmd_write_ack(cmd_write_ack), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [21:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] dev_mem [8192];
  logic [7:0] ref_mem [8192];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // SPI device model
  int          max_lat = 0;
  bit          no_ack = 0;
  bit          stray = 0;
  logic [12:0] bad_addr = 13'h1FFF;
  int          bad_left = 0;
  int unsigned ack_cyc = 0;

  initial begin
    bit pend = 0;
    int dly = 0;
    forever begin
      @(negedge clk);
      cmd_write_ack = 1'b0;
      cmd_read_ack  = 1'b0;
      read_data     = 8'($urandom);
      if (stray) begin
        cmd_write_ack = 1'b1;
        cmd_read_ack  = 1'b1;
        stray = 0;
      end else if (!rst_n) begin
        pend = 0;
      end else if ((cmd_write || cmd_read) && !no_ack) begin
        if (!pend) begin
          pend = 1;
          dly = $urandom_range(0, max_lat);
        end
        if (dly == 0) begin
          pend = 0;
          ack_cyc = cyc;
          if (cmd_write) begin
            cmd_write_ack = 1'b1;
            dev_mem[write_addr] = write_data;
          end else begin
            cmd_read_ack = 1'b1;
            if (read_addr == bad_addr && bad_left > 0) begin
              bad_left--;
              read_data = (dev_mem[read_addr] == 8'h00) ? 8'hFF : 8'h00;
            end else begin
              read_data = dev_mem[read_addr];
            end
          end
        end else begin
          dly--;
        end
      end
    end
  end

  // command monitor
  int cmd_count = 0;
  bit both_hi = 0;
  bit unstable = 0;
  initial begin
    logic prev_w = 0, prev_r = 0;
    logic [20:0] hold_w = '0;
    logic [12:0] hold_r = '0;
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_w = 0;
        prev_r = 0;
      end else begin
        if (cmd_write && cmd_read) both_hi = 1;
        if (cmd_write && !prev_w) begin
          cmd_count++;
          hold_w = {write_addr, write_data};
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
          check("spi_cmd", {1'b1, write_addr, write_data}, e);
        end else if (cmd_write && hold_w != {write_addr, write_data}) begin
          unstable = 1;
        end
        if (cmd_read && !prev_r) begin
          cmd_count++;
          hold_r = read_addr;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
          check("spi_cmd", {1'b0, read_addr, 8'h00}, e);
        end else if (cmd_read && hold_r != read_addr) begin
          unstable = 1;
        end
        prev_w = cmd_write;
        prev_r = cmd_read;
      end
    end
  end

  // reference model: expected command stream from the init table rules
  task automatic expect_init(input logic [12:0] b_addr, input int b_cnt,
                             output bit fail, output logic [12:0] f_addr);
    fail = 0;
    f_addr = '0;
    for (int e = 0; e < 4; e++) begin
      for (int att = 0; att < MR; att++) begin
        exp_q.push_back({1'b1, T_ADDR[e], T_DATA[e]});
        ref_mem[T_ADDR[e]] = T_DATA[e];
        if (!T_VER[e]) break;
        exp_q.push_back({1'b0, T_ADDR[e], 8'h00});
        if (!(T_ADDR[e] == b_addr && att < b_cnt)) break;
        if (att == MR - 1) begin
          fail = 1;
          f_addr = T_ADDR[e];
          return;
        end
      end
    end
  endtask

  // driver tasks
  task automatic wait_done(output int unsigned dcyc);
    bit seen = 0;
    dcyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (init_done || init_err) begin
        seen = 1;
        dcyc = cyc;
        break;
      end
    end
    check("init_finished", seen, 1);
  endtask

  task automatic release_and_time_first_write();
    bit seen = 0;
    int unsigned t0, fc = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_write) begin
        seen = 1;
        fc = cyc;
        break;
      end
    end
    check("first_write_seen", seen, 1);
    check("first_write_delay", fc - t0, P + 1);
  endtask

  task automatic pulse_reinit();
    @(negedge clk);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    check("reinit_clears", {init_done, init_err}, 2'b00);
  endtask

  // timing: 0 none, 1 ack delay, 2 ack delay and request latency
  task automatic host_access(input bit wr, input logic [12:0] a, input logic [7:0] d,
                             input int timing);
    bit ok = 0, cmd_seen = 0;
    int unsigned rq_c, cmd_c = 0, hk_c = 0;
    @(negedge clk);
    host_wr = wr;
    host_addr = a;
    host_wdata = d;
    host_req = 1'b1;
    rq_c = cyc;
    exp_q.push_back({wr, a, wr ? d : 8'h00});
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!cmd_seen && (cmd_write || cmd_read)) begin
        cmd_seen = 1;
        cmd_c = cyc;
      end
      if (host_ack) begin
        ok = 1;
        hk_c = cyc;
        break;
      end
    end
    host_req = 1'b0;
    check("host_ack_seen", ok, 1);
    if (timing >= 1) check("host_ack_after_spi_ack", hk_c - ack_cyc, 1);
    if (timing >= 2) check("host_req_to_cmd", cmd_c - rq_c, 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: observed no finish, expected finish");
    $fatal(1, "time limit");
  end

  // directed phases
  initial begin
    bit          fail;
    logic [12:0] faddr, a;
    logic [7:0]  d;
    bit          wr, acc;
    int unsigned dcyc, rc, fc;
    int          n;

    for (int i = 0; i < 8192; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {host_rdata, host_ack, init_done, init_err, err_addr, cmd_read,
                            cmd_write, read_addr, write_addr, write_data}, 64'h0);
    check("dbg_state_known", (^dbg_state) !== 1'bx, 1);

    // normal init with random SPI latency
    max_lat = 3;
    expect_init(13'h1FFF, 0, fail, faddr);
    n = exp_q.size();
    cmd_count = 0;
    release_and_time_first_write();
    wait_done(dcyc);
    check("init1_flags", {init_done, init_err}, 2'b10);
    check("init1_cmd_count", cmd_count, n);
    check("init1_queue_empty", exp_q.size(), 0);
    check("init_done_after_last_ack", dcyc - ack_cyc, 2);

    // directed host read then random host traffic
    dev_mem[1] = 8'hA5;
    ref_mem[1] = 8'hA5;
    max_lat = 0;
    host_access(1'b0, 13'h001, 8'h00, 2);
    check("host_rd_001", host_rdata, 8'hA5);
    max_lat = 3;
    for (int k = 0; k < 12; k++) begin
      wr = 1'($urandom_range(0, 1));
      a = 13'($urandom_range(13'h100, 13'h1FFF));
      d = 8'($urandom);
      host_access(wr, a, d, 1);
      if (wr) ref_mem[a] = d;
      else check("host_rd_random", host_rdata, ref_mem[a]);
    end

    // acks with nothing outstanding are ignored
    @(negedge clk);
    stray = 1;
    acc = 0;
    repeat (3) begin
      @(negedge clk);
      acc = acc | host_ack | cmd_write | cmd_read;
    end
    check("stray_ack_ignored", acc, 0);
    check("stray_ack_flags", {init_done, init_err}, 2'b10);

    // one wrong read-back at 0x00D, then success
    bad_addr = 13'h00D;
    bad_left = 1;
    expect_init(13'h00D, 1, fail, faddr);
    n = exp_q.size();
    cmd_count = 0;
    pulse_reinit();
    wait_done(dcyc);
    check("retry_once_flags", {init_done, init_err}, 2'b10);
    check("retry_once_cmd_count", cmd_count, n);
    check("retry_once_queue_empty", exp_q.size(), 0);

    // persistent mismatch at 0x014 exhausts retries
    bad_addr = 13'h014;
    bad_left = 99;
    expect_init(13'h014, 99, fail, faddr);
    n = exp_q.size();
    cmd_count = 0;
    pulse_reinit();
    wait_done(dcyc);
    repeat (2) @(negedge clk);
    check("stuck_flags", {init_done, init_err}, {1'b0, fail});
    check("stuck_err_addr", err_addr, faddr);
    check("stuck_cmd_count", cmd_count, n);
    check("stuck_queue_empty", exp_q.size(), 0);

    // debug host read while failed
    dev_mem[13'h0ABC] = 8'hC3;
    ref_mem[13'h0ABC] = 8'hC3;
    host_access(1'b0, 13'h0ABC, 8'h00, 1);
    check("fail_host_rd", host_rdata, 8'hC3);
    check("fail_still_err", init_err, 1);

    // watchdog on an unanswered table write
    bad_left = 0;
    no_ack = 1;
    exp_q.push_back({1'b1, 13'h000, 8'h3C});
    cmd_count = 0;
    pulse_reinit();
    rc = 0;
    fc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_write) begin rc = cyc; break; end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!cmd_write) begin fc = cyc; break; end
    end
    check("watchdog_cmd_width", fc - rc, TO);
    @(negedge clk);
    check("watchdog_flags", {init_done, init_err}, 2'b01);
    check("watchdog_err_addr", err_addr, 13'h000);
    check("watchdog_cmd_count", cmd_count, 1);

    // host read timeout returns zero data
    host_access(1'b0, 13'h0321, 8'h00, 0);
    check("host_timeout_rdata", host_rdata, 8'h00);
    check("host_timeout_err_addr", err_addr, 13'h0321);
    check("host_timeout_err", init_err, 1);

    // recovery through reinit with a responsive device
    no_ack = 0;
    expect_init(13'h1FFF, 0, fail, faddr);
    n = exp_q.size();
    cmd_count = 0;
    pulse_reinit();
    wait_done(dcyc);
    check("recover_flags", {init_done, init_err}, 2'b10);
    check("recover_cmd_count", cmd_count, n);

    // asynchronous reset during read-back of 0x014
    max_lat = 3;
    expect_init(13'h1FFF, 0, fail, faddr);
    pulse_reinit();
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_read && read_addr == 13'h014) begin acc = 1; break; end
    end
    check("reached_cfg_rd_014", acc, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {cmd_read, cmd_write, init_done, init_err, host_ack}, 5'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    expect_init(13'h1FFF, 0, fail, faddr);
    n = exp_q.size();
    cmd_count = 0;
    release_and_time_first_write();
    wait_done(dcyc);
    check("reset_restart_flags", {init_done, init_err}, 2'b10);
    check("reset_restart_cmd_count", cmd_count, n);
    check("reset_restart_queue_empty", exp_q.size(), 0);

    // whole-run protocol properties
    check("cmd_never_both_high", both_hi, 0);
    check("cmd_fields_stable", unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_cfg_sequencer.md
# adc_cfg_sequencer

Sequences the ADC SPI register-access block: after reset it waits out the ADC power-up time, then writes a fixed initialisation table. Each table entry is optionally read back and compared, with bounded retry. After that it arbitrates host register read/write requests onto the same single-command SPI port. It sits between the system control logic and the ADC SPI block and is the only driver of that block's command inputs.

## Interface
- PWRUP_CYCLES, 1000: clk cycles to wait after reset release before the first SPI command.
- MAX_RETRY, 3: write+verify attempts per table entry before declaring failure.
- ACK_TIMEOUT, 65535: clk cycles a command may stay unacknowledged before failure.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- reinit  in  1  one-cycle pulse; restarts the table from entry 0. Honoured only in READY or FAIL.
- host_req  in  1  level request; host_wr/host_addr/host_wdata stable until host_ack.
- host_wr  in  1  1 = write, 0 = read.
- host_addr  in  13  register address.
- host_wdata  in  8  write data.
- host_rdata  out  8  read data; valid with host_ack.
- host_ack  out  1  one-cycle completion pulse.
- init_done  out  1  table written and verified; cleared by reinit.
- init_err  out  1  sticky failure flag; cleared by reinit.
- err_addr  out  13  address of the failing entry.
- cmd_read  out  1  SPI read command.
- cmd_write  out  1  SPI write command.
- read_addr  out  13  SPI read address.
- write_addr  out  13  SPI write address.
- write_data  out  8  SPI write data.
- read_data  in  8  SPI read result; valid while cmd_read_ack is high.
- cmd_read_ack  in  1  SPI read done (1 cycle).
- cmd_write_ack  in  1  SPI write done (1 cycle).

## Operation
Internal ROM, INIT_LEN = 4, fields {addr, data, verify}:
- idx0: 0x000 ← 0x3C, verify 0 (soft reset).
- idx1: 0x014 ← 0x01, verify 1.
- idx2: 0x00D ← 0x00, verify 1.
- idx3: 0x0FF ← 0x01, verify 0 (self-clearing transfer).

States:
- PWRUP
  - Count up to PWRUP_CYCLES-1, then go to CFG_WR with idx = 0 and retry = 0.
- CFG_WR
  - Drive the ROM entry on write_addr/write_data and assert cmd_write.
  - On cmd_write_ack: go to CFG_RD if verify = 1, otherwise CFG_NEXT.
- CFG_RD
  - Drive read_addr = entry addr and assert cmd_read.
  - On cmd_read_ack with read_data == entry data: go to CFG_NEXT.
  - On a mismatch: retry increments. If retry + 1 == MAX_RETRY, go to FAIL. Otherwise go back to CFG_WR for the same entry.
- CFG_NEXT
  - idx increments and retry clears.
  - If idx was INIT_LEN-1, go to READY and set init_done. Otherwise go to CFG_WR.
- READY
  - reinit takes priority over host_req: clear init_done/init_err and go to CFG_WR with idx = 0. Power-up is not repeated.
  - Otherwise host_req latches wr/addr/wdata and goes to HOST.
- HOST
  - Assert cmd_write or cmd_read with the latched fields.
  - On the matching ack: pulse host_ack, capture read_data into host_rdata on reads, and return to the originating state (READY or FAIL).
- FAIL
  - init_err = 1 and err_addr = failing entry address.
  - Host requests are still served (debug access).
  - reinit behaves as in READY.

Rules:
- Watchdog:
  - Counts the cycles a command has been asserted without its ack.
  - On reaching ACK_TIMEOUT-1: drop the command, set err_addr to the current address, go to FAIL.
  - This applies in HOST as well; a host timeout gives host_ack = 1 with host_rdata = 0x00.
- Acks arriving when no command is outstanding are ignored. Acks of the wrong type are also ignored.
- cmd_read and cmd_write are never high together.
- host_rdata holds its value until the next read completes.

## Timing
- Reset values: all outputs 0; state PWRUP; counters 0.
- Command outputs:
  - cmd_* and the addr/data outputs are registered.
  - cmd_* rises on the first clock of CFG_WR/CFG_RD/HOST and stays high up to and including the ack cycle.
  - cmd_* is low in the cycle after the ack.
  - Addr/data outputs are stable from the rise of cmd_* through the ack cycle.
- First cmd_write rises PWRUP_CYCLES+1 cycles after rst_n deasserts.
- host_ack occurs the cycle after the SPI ack. The minimum host_req→cmd latency is 2 cycles.
- init_done rises 2 cycles after the final table ack (via CFG_NEXT).
- If host_req stays high after host_ack, it is taken as a new request.
- rst_n asserted mid-transaction:
  - Immediate return to reset values; commands drop asynchronously.
  - The SPI block's own reset is shared, so no stale ack follows.

## Test plan
- Normal init, PWRUP_CYCLES = 16, SPI model echoes written data → writes to 0x000, 0x014 (read-back), 0x00D (read-back), 0x0FF in that order; init_done = 1; init_err = 0; exactly 6 commands.
- Model returns 0x00 for 0x014 with MAX_RETRY = 3 → three write/read pairs to 0x014; init_err = 1; err_addr = 0x014; no access to 0x00D.
- Model returns a wrong value once for 0x00D → one retry, then init_done = 1.
- Host read 0x001 after init, model returns 0xA5 → cmd_read held until ack; host_ack 1 cycle later; host_rdata = 0xA5.
- Model never acks, ACK_TIMEOUT = 32 → cmd_write drops after 32 cycles; FAIL; err_addr = 0x000. Then reinit with a responsive model → init_done = 1, init_err = 0.
- rst_n pulsed low during CFG_RD of 0x014 → cmd_read = 0 immediately; the sequence restarts with PWRUP.
